apb_m: RTL

APB requester (master) that converts single-beat commands from local logic into APB setup/access transfers toward one `apb_s`-style completer. It owns the 32-bit address / 8-bit data APB bus used by the slave side of the design, waits out completer wait states, and returns read data plus error status as a one-cycle response pulse. One transfer is in flight at a time, with no pipelining.

---
 rtl/apb_m.sv | 136 +++++++++++++
 1 files changed

// File: rtl/apb_m.sv
// APB requester: one single-beat command at a time, converted to SETUP/ACCESS on the APB bus.
// Optional ACCESS watchdog is built only when APB_M_TIMEOUT_EN is defined.
module apb_m #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [7:0]  pwdata,
    input  logic [7:0]  prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_done;
    logic   w_abort;
    logic   w_to_hit;

`ifdef APB_M_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;

    // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_to_hit = (r_wait_cnt == TO_LAST);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == ACCESS && !pready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    assign w_to_hit    = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus controls are registered from the next state so they line up with it.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= IDLE;
            cmd_ready <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_M_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            cmd_ready <= (w_state_nxt == IDLE);
            psel      <= (w_state_nxt != IDLE);
            penable   <= (w_state_nxt == ACCESS);
            rsp_valid <= w_done | w_abort;
            if (w_accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            if (w_done) begin
                rsp_err   <= pslverr;
                rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
`ifdef APB_M_TIMEOUT_EN
                rsp_timeout <= 1'b0;
`endif
            end
            if (w_abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
`ifdef APB_M_TIMEOUT_EN
                rsp_timeout <= 1'b1;
`endif
            end
        end
    end

endmodule
